// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic (read and write sides).
package fifo_pkg;

  localparam int unsigned DefAddrSize = 4;
  localparam int unsigned DefDataSize = 8;

  // Pointer helpers work on a zero-extended 32-bit vector. Callers extend their
  // ADDRSIZE+1 pointer in and truncate the result back. Zero upper bits do not
  // disturb either conversion, so one function serves every ADDRSIZE.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer in arrival order, presenting the oldest word as rdata.
module rd_skid_buf #(
  parameter int unsigned DATASIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                in_valid,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                pop,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic [1:0]          buf_cnt
);

  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;
  logic [1:0]          cnt_q, cnt_d;

  // Next-state: push into the first free slot, pop shifts tail into head.
  // The caller guarantees no push into a full buffer and no pop when empty.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({in_valid, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count unchanged; the arriving word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer state register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata   = head_q;
  assign rvalid  = (cnt_q != 2'd0);
  assign buf_cnt = cnt_q;

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-side FIFO control: Gray/binary read pointer, empty/almost-empty/level
// flags, memory read issue and first-word-fall-through output.
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = DefAddrSize,
  parameter int unsigned DATASIZE  = DefDataSize,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rren,
  input  logic [DATASIZE-1:0] rmem_data,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int unsigned PtrW = ADDRSIZE + 1;

  logic [PtrW-1:0] rbin_q, rbin_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] rlevel_q, rlevel_d;
  logic [PtrW-1:0] wbin_s;
  logic            rempty_q, rempty_d;
  logic            raempty_q, raempty_d;
  logic            inflight_q;
  logic [1:0]      buf_cnt;
  logic [2:0]      occ;
  logic            pop;
  logic            space;

  // Read issue and next pointer/flag values. A read is issued only when the
  // buffer can absorb it next cycle, counting the word already in flight.
  always_comb begin
    pop       = rvalid & rready;
    occ       = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    space     = (occ < 3'd2);
    rren      = ~rempty_q & space;
    rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, rren};
    rptr_d    = PtrW'(bin2gray(32'(rbin_d)));
    wbin_s    = PtrW'(gray2bin(32'(rq2_wptr)));
    // Compare against the next pointer so a write landing with the last read
    // keeps the FIFO non-empty.
    rempty_d  = (rptr_d == rq2_wptr);
    rlevel_d  = wbin_s - rbin_d;
    raempty_d = (32'(rlevel_d) <= AEMPTY_TH);
  end

  // Pointer, flag and in-flight registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rlevel_q   <= '0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rlevel_q   <= rlevel_d;
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
      inflight_q <= rren;
    end
  end

  rd_skid_buf #(
    .DATASIZE (DATASIZE)
  ) u_buf (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .in_valid (inflight_q),
    .in_data  (rmem_data),
    .pop      (pop),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .buf_cnt  (buf_cnt)
  );

  assign rptr    = rptr_q;
  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Directed bench for rptr_empty_fwft with a behavioural 1-cycle-latency memory.
module tb_rptr_empty_fwft;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic [PW-1:0] rq2_wptr;
  logic [PW-1:0] rptr;
  logic [AW-1:0] raddr;
  logic          rren;
  logic [DW-1:0] rmem_data = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic          rempty;
  logic          raempty;
  logic [PW-1:0] rlevel;

  logic [DW-1:0] mem [16];
  int n_vec = 0;
  int n_err = 0;
  int wbin  = 0;

  rptr_empty_fwft #(
    .ADDRSIZE  (AW),
    .DATASIZE  (DW),
    .AEMPTY_TH (2)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rptr      (rptr),
    .raddr     (raddr),
    .rren      (rren),
    .rmem_data (rmem_data),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .rempty    (rempty),
    .raempty   (raempty),
    .rlevel    (rlevel)
  );

  always #5 rclk = ~rclk;

  // Registered-read memory model.
  always @(posedge rclk) begin
    if (rren) rmem_data <= mem[raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin % 16] = d;
    wbin = (wbin + 1) % 32;
    rq2_wptr = to_gray(wbin);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rempty"},  32'(rempty),  32'd1);
    check_eq({tag, "_raempty"}, 32'(raempty), 32'd1);
    check_eq({tag, "_rvalid"},  32'(rvalid),  32'd0);
    check_eq({tag, "_rptr"},    32'(rptr),    32'd0);
    check_eq({tag, "_rlevel"},  32'(rlevel),  32'd0);
    check_eq({tag, "_rren"},    32'(rren),    32'd0);
  endtask

  // One-cycle rready pulse, then a refill cycle with rready low.
  task automatic pop_one(input logic [DW-1:0] d, input int lvl, input int ae);
    rready = 1'b1;
    #1;
    check_eq("th_rdata", 32'(rdata), 32'(d));
    check_eq("th_rren",  32'(rren),  32'd1);
    tick();
    rready = 1'b0;
    check_eq("th_rlevel",  32'(rlevel),  32'(lvl));
    check_eq("th_raempty", 32'(raempty), 32'(ae));
    tick();
  endtask

  initial begin
    int cnt;
    int lvl;
    rready   = 1'b0;
    rq2_wptr = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Power-on reset.
    #2 rrst_n = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    check_reset_state("por");
    @(negedge rclk) rrst_n = 1'b1;
    tick();
    tick();
    check_eq("idle_rren",   32'(rren),   32'd0);
    check_eq("idle_rempty", 32'(rempty), 32'd1);

    // Single word: first-word latency.
    rready = 1'b1;
    write_word(8'hA5);
    check_eq("sw_c_rren", 32'(rren), 32'd0);
    tick();
    check_eq("sw_c1_rempty",  32'(rempty),  32'd0);
    check_eq("sw_c1_rren",    32'(rren),    32'd1);
    check_eq("sw_c1_rlevel",  32'(rlevel),  32'd1);
    check_eq("sw_c1_raempty", 32'(raempty), 32'd1);
    tick();
    check_eq("sw_c2_rempty", 32'(rempty), 32'd1);
    check_eq("sw_c2_rptr",   32'(rptr),   32'h01);
    check_eq("sw_c2_rvalid", 32'(rvalid), 32'd0);
    check_eq("sw_c2_rlevel", 32'(rlevel), 32'd0);
    tick();
    check_eq("sw_c3_rvalid", 32'(rvalid), 32'd1);
    check_eq("sw_c3_rdata",  32'(rdata),  32'hA5);
    tick();
    check_eq("sw_c4_rvalid", 32'(rvalid), 32'd0);

    // Burst of 16 words (full FIFO) with rready high.
    for (int i = 0; i < 16; i++) write_word(8'(8'h10 + i));
    tick();
    for (int i = 0; i < 20; i++) begin
      lvl = (i <= 16) ? 16 - i : 0;
      check_eq("bu_rlevel",  32'(rlevel),  32'(lvl));
      check_eq("bu_raempty", 32'(raempty), 32'(lvl <= 2));
      check_eq("bu_rren",    32'(rren),    32'(i < 16));
      check_eq("bu_rvalid",  32'(rvalid),  32'(i >= 2 && i <= 17));
      if (i >= 2 && i <= 17) check_eq("bu_rdata", 32'(rdata), 32'(8'h10 + i - 2));
      tick();
    end
    check_eq("bu_rptr",   32'(rptr),   32'h19);
    check_eq("bu_rempty", 32'(rempty), 32'd1);

    // Backpressure: only two reads issue while rready is low.
    rready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'(8'h40 + i));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (rren) cnt++;
      tick();
    end
    check_eq("bp_nreads", 32'(cnt),    32'd2);
    check_eq("bp_rvalid", 32'(rvalid), 32'd1);
    check_eq("bp_rdata",  32'(rdata),  32'h40);
    check_eq("bp_rlevel", 32'(rlevel), 32'd2);
    tick();
    check_eq("bp_hold",   32'(rdata),  32'h40);
    rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_rvalid_run", 32'(rvalid), 32'd1);
      check_eq("bp_rdata_run",  32'(rdata),  32'(8'h40 + k));
      tick();
    end
    check_eq("bp_rvalid_end", 32'(rvalid), 32'd0);
    check_eq("bp_rempty_end", 32'(rempty), 32'd1);

    // Wrap-around: drain up to rbin 31, then one word across the wrap.
    for (int i = 0; i < 10; i++) write_word(8'(8'h60 + i));
    repeat (16) tick();
    check_eq("wr_rptr31",  32'(rptr),   32'h10);
    check_eq("wr_rempty",  32'(rempty), 32'd1);
    check_eq("wr_rvalid",  32'(rvalid), 32'd0);
    write_word(8'hEE);
    check_eq("wr_wptr0", 32'(rq2_wptr), 32'd0);
    tick();
    check_eq("wr_c1_rempty", 32'(rempty), 32'd0);
    check_eq("wr_c1_rren",   32'(rren),   32'd1);
    check_eq("wr_c1_raddr",  32'(raddr),  32'd15);
    check_eq("wr_c1_rlevel", 32'(rlevel), 32'd1);
    tick();
    check_eq("wr_c2_rptr",   32'(rptr),   32'd0);
    check_eq("wr_c2_rempty", 32'(rempty), 32'd1);
    tick();
    check_eq("wr_c3_rvalid", 32'(rvalid), 32'd1);
    check_eq("wr_c3_rdata",  32'(rdata),  32'hEE);
    tick();
    check_eq("wr_c4_rvalid", 32'(rvalid), 32'd0);

    // Almost-empty threshold: level stepped 5 -> 4 -> 3 -> 2.
    rready = 1'b0;
    write_word(8'h50);
    write_word(8'h51);
    repeat (5) tick();
    for (int i = 0; i < 5; i++) write_word(8'(8'h52 + i));
    tick();
    check_eq("th_rlevel5",  32'(rlevel),  32'd5);
    check_eq("th_raempty5", 32'(raempty), 32'd0);
    check_eq("th_rdata5",   32'(rdata),   32'h50);
    check_eq("th_rren5",    32'(rren),    32'd0);
    pop_one(8'h50, 4, 0);
    pop_one(8'h51, 3, 0);
    pop_one(8'h52, 2, 1);

    // Mid-stream asynchronous reset with a full buffer.
    #2 rrst_n = 1'b0;
    #1;
    check_reset_state("mid");
    wbin = 0;
    rq2_wptr = '0;
    tick();
    tick();
    @(negedge rclk) rrst_n = 1'b1;
    tick();
    tick();
    check_eq("post_rren",   32'(rren),   32'd0);
    check_eq("post_rempty", 32'(rempty), 32'd1);
    check_eq("post_rvalid", 32'(rvalid), 32'd0);
    rready = 1'b1;
    write_word(8'h77);
    repeat (3) tick();
    check_eq("post_rvalid_w", 32'(rvalid), 32'd1);
    check_eq("post_rdata_w",  32'(rdata),  32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rptr_empty_fwft.md
Name: rptr_empty_fwft

Overview:
- Read-side control for the dual-clock FIFO; mirror of the write-pointer/full stage, living entirely in the read clock domain.
- Maintains binary/Gray read pointers and registered empty and almost-empty flags against the synchronized write pointer rq2_wptr.
- Issues reads to the dual-port memory, which has a 1-cycle registered read.
- Presents data to the consumer as first-word-fall-through through a 2-entry output buffer with a valid/ready handshake.

Parameters:
- ADDRSIZE, 4: memory address width; FIFO depth 2^ADDRSIZE; pointers ADDRSIZE+1 bits.
- DATASIZE, 8: data word width.
- AEMPTY_TH, 2: raempty asserted when synchronized level <= AEMPTY_TH.

Ports:
- rclk  in  1  read clock.
- rrst_n  in  1  asynchronous active-low reset.
- rq2_wptr  in  ADDRSIZE+1  write Gray pointer, already 2-flop synchronized into rclk.
- rptr  out  ADDRSIZE+1  registered Gray read pointer, to the write-domain synchronizer.
- raddr  out  ADDRSIZE  memory read address (binary rbin[ADDRSIZE-1:0]).
- rren  out  1  memory read enable, combinational.
- rmem_data  in  DATASIZE  memory read data, valid the cycle after rren.
- rdata  out  DATASIZE  head-of-buffer data.
- rvalid  out  1  rdata valid.
- rready  in  1  consumer accepts rdata.
- rempty  out  1  registered: memory holds no unread word.
- raempty  out  1  registered almost-empty.
- rlevel  out  ADDRSIZE+1  registered count of unread words in memory (excludes the output buffer).

Behaviour:
- Reset (async, rrst_n low): rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, rvalid=0, buffer count=0, inflight=0. rdata don't-care, driven 0.
- pop = rvalid & rready.
- space = (buf_cnt + inflight - pop) < 2, where buf_cnt is 0..2 and inflight is 0/1 (a read issued last cycle).
- rren = ~rempty & space.
- rbinnext = rbin + rren. rgraynext = (rbinnext>>1) ^ rbinnext. Both are registered into rbin/rptr each cycle.
- Empty flag, registered: rempty <= (rgraynext == rq2_wptr).
- Level and almost-empty:
  - wbin_s = gray2bin(rq2_wptr).
  - rlevel <= wbin_s - rbinnext, computed modulo 2^(ADDRSIZE+1).
  - raempty <= (wbin_s - rbinnext) <= AEMPTY_TH.
- Pointer wrap: all pointer arithmetic is modulo 2^(ADDRSIZE+1). The MSB toggles every 2^ADDRSIZE reads. Empty requires all ADDRSIZE+1 Gray bits equal.
- Read latency:
  - rren high in cycle t; rmem_data is sampled at the end of t+1 into the buffer; rvalid is high from t+2.
  - First word: rq2_wptr becomes non-empty in cycle c → rempty low in c+1 → rren in c+1 → rvalid in c+3.
- Output buffer:
  - 2-entry FIFO in arrival order; rdata is always the oldest entry.
  - A write (arriving word) and a pop in the same cycle are both honoured: count unchanged, head advances.
  - rvalid = (buf_cnt != 0).
  - While rvalid & ~rready, rdata and rvalid hold stable.
  - The buffer never overflows; the space rule guarantees buf_cnt + inflight <= 2.
- Throughput: with rready held high and the memory non-empty, one word per rclk.
- Simultaneous events: rq2_wptr advancing in the same cycle as the last read leaves rempty = 0 next cycle, because the comparison uses rgraynext against the current rq2_wptr.
- Mid-operation reset: an in-flight word is discarded. All outputs return to reset values immediately (async assert). Normal operation resumes on the first rclk after deassertion.
- rready is ignored while rvalid = 0.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parameterized by ADDRSIZE; also usable by the write side.
  - constants for default ADDRSIZE and DATASIZE.
- One sub-module, rd_skid_buf: the 2-entry output buffer.
  - Inputs: rclk, rrst_n, in_valid (= inflight), in_data (= rmem_data), pop.
  - Outputs: rdata, rvalid, buf_cnt.
- rptr_empty_fwft holds the pointers, flags, level, and the rren/space logic.

Test Plan:
- Reset: rrst_n low mid-stream → rempty=1, raempty=1, rvalid=0, rptr=0, rlevel=0 immediately. After release, rq2_wptr=0 → rren stays 0.
- Single word: rq2_wptr 0→1 in cycle c → rempty=0 at c+1, rren=1 at c+1, rvalid=1 with the written word at c+3. Then rempty=1, rptr=00001.
- Burst: rq2_wptr jumps to 16 (Gray 11000, i.e. full) with rready=1 → 16 consecutive rvalid cycles, data in order. rlevel counts 16 down to 0. raempty rises when rlevel<=2. Final rptr=11000.
- Backpressure: 4 words available, rready=0 → rren fires exactly twice, buf_cnt=2, rdata holds word0. rready=1 → words 0..3 delivered back-to-back with no gap after word1.
- Wrap-around: rbin at 31, one word present → read advances rbin to 0 and rptr to 00000. rempty asserts when rq2_wptr=00000.
- Threshold: AEMPTY_TH=2, level stepped 5→4→3→2 → raempty=0,0,0,1, each registered one cycle after the level change.
